// File: rtl/csr_uart.sv
// ---------------------------------------------------------------------------
// csr_uart
//   8N1 UART at a fixed baud rate, exposed through one CSR address.
//   A CSR write (modify==01) queues one byte for transmission; a CSR read
//   returns the status word and, when the read strobe is set, acknowledges
//   the received byte. rdata/valid are zero whenever the block is not
//   addressed so they can be OR-combined with neighbouring CSR peripherals.
//
//   Status word: {21'b0, overrun, rx_full, tx_busy, rx_data[7:0]}
//
// Ports
//   clk     in   1   clock, rising edge
//   rstn    in   1   synchronous reset, active-low
//   read    in   1   CSR read strobe (acknowledges the received byte)
//   modify  in   2   00 none, 01 write, 10 set bits, 11 clear bits
//   wdata   in   32  CSR write data (bits 7:0 = byte to transmit)
//   addr    in   12  CSR address
//   rdata   out  32  registered read data, 0 when not selected
//   valid   out  1   registered address-match flag
//   rx      in   1   asynchronous serial input, idle high
//   tx      out  1   registered serial output, idle high
// ---------------------------------------------------------------------------
module csr_uart #(
    parameter logic [11:0] BASE_ADDR  = 12'h7c0,
    parameter int          CLOCK_RATE = 12_000_000,
    parameter int          BAUD_RATE  = 115200
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [1:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        tx
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

    // ---------------- registers ----------------
    tx_state_t       tx_state_r;
    logic [CW-1:0]   tx_cnt_r;
    logic [7:0]      tx_shift_r;
    logic [2:0]      tx_bit_r;
    logic            tx_line_r;
    logic            tx_busy_r;

    logic            rx_meta_r;
    logic            rx_sync_r;
    rx_state_t       rx_state_r;
    logic [CW-1:0]   rx_cnt_r;
    logic [7:0]      rx_shift_r;
    logic [2:0]      rx_bit_r;
    logic [7:0]      rx_data_r;
    logic            rx_full_r;
    logic            overrun_r;

    logic [31:0]     rdata_r;
    logic            valid_r;

    // ---------------- next-state signals ----------------
    tx_state_t       tx_state_s;
    logic [CW-1:0]   tx_cnt_s;
    logic [7:0]      tx_shift_s;
    logic [2:0]      tx_bit_s;
    logic            tx_line_s;

    rx_state_t       rx_state_s;
    logic [CW-1:0]   rx_cnt_s;
    logic [7:0]      rx_shift_s;
    logic [2:0]      rx_bit_s;
    logic            rx_done_s;

    logic [7:0]      rx_data_s;
    logic            rx_full_s;
    logic            overrun_s;

    logic            sel_s;
    logic            wr_acc_s;
    logic            ack_s;
    logic [31:0]     status_s;

    assign sel_s    = (addr == BASE_ADDR);
    assign wr_acc_s = sel_s && (modify == 2'b01) && !tx_busy_r;
    assign ack_s    = sel_s && read;
    assign status_s = {21'd0, overrun_r, rx_full_r, tx_busy_r, rx_data_r};

    assign rdata = rdata_r;
    assign valid = valid_r;
    assign tx    = tx_line_r;

    // TX next-state: start bit, 8 data bits LSB first, stop bit, DIV cycles each
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_shift_s = tx_shift_r;
        tx_bit_s   = tx_bit_r;
        tx_line_s  = tx_line_r;
        case (tx_state_r)
            TX_IDLE: begin
                tx_line_s = 1'b1;
                if (wr_acc_s) begin
                    tx_state_s = TX_START;
                    tx_cnt_s   = '0;
                    tx_shift_s = wdata[7:0];
                    tx_line_s  = 1'b0;
                end else begin
                    tx_cnt_s   = '0;
                end
            end
            TX_START: begin
                if (tx_cnt_r == DIV_LAST) begin
                    tx_state_s = TX_DATA;
                    tx_cnt_s   = '0;
                    tx_bit_s   = 3'd0;
                    tx_line_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_s   = tx_cnt_r + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == DIV_LAST) begin
                    tx_cnt_s = '0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = TX_STOP;
                        tx_line_s  = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        tx_line_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            TX_STOP: begin
                tx_line_s = 1'b1;
                if (tx_cnt_r == DIV_LAST) begin
                    tx_state_s = TX_IDLE;
                    tx_cnt_s   = '0;
                end else begin
                    tx_cnt_s   = tx_cnt_r + 1'b1;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = '0;
                tx_line_s  = 1'b1;
            end
        endcase
    end

    // RX next-state: detect start edge, confirm at half bit, then sample bit centres
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_shift_s = rx_shift_r;
        rx_bit_s   = rx_bit_r;
        rx_done_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_s = '0;
                if (!rx_sync_r) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s = '0;
                    rx_bit_s = 3'd0;
                    // A start bit that has gone high again by mid-bit was a glitch
                    if (!rx_sync_r) begin
                        rx_state_s = RX_DATA;
                    end else begin
                        rx_state_s = RX_IDLE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == DIV_LAST) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_bit_s   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == DIV_LAST) begin
                    rx_cnt_s = '0;
                    if (rx_sync_r) begin
                        rx_state_s = RX_IDLE;
                        rx_done_s  = 1'b1;
                    end else begin
                        // Framing error: drop the byte and wait for the line to idle
                        rx_state_s = RX_WAIT;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            RX_WAIT: begin
                rx_cnt_s = '0;
                if (rx_sync_r) begin
                    rx_state_s = RX_IDLE;
                end else begin
                    rx_state_s = RX_WAIT;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                rx_cnt_s   = '0;
            end
        endcase
    end

    // Receive buffer flags: a completing byte takes priority over a read ack
    always_comb begin
        rx_data_s = rx_data_r;
        rx_full_s = rx_full_r;
        overrun_s = overrun_r;
        if (rx_done_s) begin
            rx_data_s = rx_shift_s;
            rx_full_s = 1'b1;
            overrun_s = overrun_r | rx_full_r;
        end else if (ack_s) begin
            rx_full_s = 1'b0;
            overrun_s = 1'b0;
        end else begin
            rx_full_s = rx_full_r;
        end
    end

    // State registers for both FSMs, the RX synchronizer and the CSR read port
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_shift_r <= 8'd0;
            tx_bit_r   <= 3'd0;
            tx_line_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_shift_r <= 8'd0;
            rx_bit_r   <= 3'd0;
            rx_data_r  <= 8'd0;
            rx_full_r  <= 1'b0;
            overrun_r  <= 1'b0;
            rdata_r    <= 32'd0;
            valid_r    <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_shift_r <= tx_shift_s;
            tx_bit_r   <= tx_bit_s;
            tx_line_r  <= tx_line_s;
            tx_busy_r  <= (tx_state_s != TX_IDLE);
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_shift_r <= rx_shift_s;
            rx_bit_r   <= rx_bit_s;
            rx_data_r  <= rx_data_s;
            rx_full_r  <= rx_full_s;
            overrun_r  <= overrun_s;
            rdata_r    <= sel_s ? status_s : 32'd0;
            valid_r    <= sel_s;
        end
    end

endmodule

// File: tb/tb_csr_uart.sv
// ---------------------------------------------------------------------------
// tb_csr_uart
//   Directed bench for csr_uart with CLOCK_RATE=16, BAUD_RATE=1 (DIV=16).
//   Inputs change 1 time unit after the rising edge; outputs are checked at
//   the same point, i.e. they reflect the most recent edge.
// ---------------------------------------------------------------------------
module tb_csr_uart;

    localparam logic [11:0] BASE = 12'h7c0;

    logic        clk;
    logic        rstn;
    logic        read;
    logic [1:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic        rx;
    logic        tx;

    int n_tests;
    int n_fail;

    csr_uart #(
        .BASE_ADDR (12'h7c0),
        .CLOCK_RATE(16),
        .BAUD_RATE (1)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .read  (read),
        .modify(modify),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .valid (valid),
        .rx    (rx),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        addr   = 12'h000;
        read   = 1'b0;
        modify = 2'b00;
        wdata  = 32'd0;
    endtask

    // One-cycle CSR access at BASE; returns the registered read data
    task automatic csr_read(input logic ack, output logic [31:0] d);
        addr   = BASE;
        read   = ack;
        modify = 2'b00;
        tick();
        d = rdata;
        chk("read_valid", {31'd0, valid}, 32'd1);
        idle_bus();
    endtask

    // Serial frame on rx: start, 8 data bits LSB first, stop, then idle
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (16) tick();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (16) tick();
        end
        rx = stop_bit;
        repeat (16) tick();
        rx = 1'b1;
        repeat (8) tick();
    endtask

    // Run n cycles and report whether tx was ever low
    task automatic watch_tx(input int n, output logic saw_low);
        saw_low = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (tx === 1'b0) saw_low = 1'b1;
            tick();
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        low;
        logic [9:0]  frame;

        n_tests = 0;
        n_fail  = 0;
        rstn    = 1'b0;
        rx      = 1'b1;
        idle_bus();
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        // Reset state
        chk("rst_tx",    {31'd0, tx},    32'd1);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_rdata", rdata,          32'd0);
        csr_read(1'b0, d);
        chk("rst_status", d, 32'd0);
        tick();
        chk("valid_drop", {31'd0, valid}, 32'd0);

        // TX 0x55, with a dropped 0xAA write and a status read mid-frame
        addr   = BASE;
        modify = 2'b01;
        wdata  = 32'h0000_0055;
        tick();
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 160; i++) begin
            if ((i % 16) == 8) chk($sformatf("tx_bit%0d", i / 16), {31'd0, tx}, {31'd0, frame[i / 16]});
            if (i == 21) chk("busy_mid", rdata, 32'h0000_0100);
            addr   = (i == 20) ? BASE : 12'h000;
            modify = (i == 20) ? 2'b01 : 2'b00;
            wdata  = 32'h0000_00AA;
            tick();
        end
        idle_bus();
        csr_read(1'b0, d);
        chk("busy_clear", d, 32'd0);
        watch_tx(60, low);
        chk("no_second_frame", {31'd0, low}, 32'd0);

        // Set/clear modifies do not transmit
        addr   = BASE;
        modify = 2'b10;
        wdata  = 32'hFFFF_FFFF;
        tick();
        modify = 2'b11;
        tick();
        idle_bus();
        watch_tx(40, low);
        chk("modify_1x_no_tx", {31'd0, low}, 32'd0);

        // RX 0xA3 and acknowledge
        send_rx(8'hA3, 1'b1);
        csr_read(1'b0, d);
        chk("rx_a3", d, 32'h0000_02A3);
        csr_read(1'b1, d);
        chk("rx_ack_ret", d, 32'h0000_02A3);
        csr_read(1'b0, d);
        chk("rx_after_ack", d, 32'h0000_00A3);

        // Overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        csr_read(1'b1, d);
        chk("overrun", d, 32'h0000_0622);
        csr_read(1'b0, d);
        chk("overrun_ack", d, 32'h0000_0022);

        // Framing error: byte dropped, flags unchanged, then recovery
        send_rx(8'h33, 1'b0);
        csr_read(1'b0, d);
        chk("frame_err", d, 32'h0000_0022);
        send_rx(8'h5A, 1'b1);
        csr_read(1'b0, d);
        chk("rx_recover", d, 32'h0000_025A);

        // Neighbouring address: no response and no side effects
        addr   = 12'h7c1;
        read   = 1'b1;
        modify = 2'b01;
        wdata  = 32'h0000_0000;
        tick();
        chk("addr_valid", {31'd0, valid}, 32'd0);
        chk("addr_rdata", rdata,          32'd0);
        idle_bus();
        watch_tx(20, low);
        chk("addr_no_tx", {31'd0, low}, 32'd0);
        csr_read(1'b0, d);
        chk("addr_no_ack", d, 32'h0000_025A);

        // Reset in the middle of a transmit frame
        addr   = BASE;
        modify = 2'b01;
        wdata  = 32'h0000_0000;
        tick();
        idle_bus();
        repeat (30) tick();
        chk("midtx_low", {31'd0, tx}, 32'd0);
        rstn = 1'b0;
        tick();
        chk("rst_mid_tx", {31'd0, tx}, 32'd1);
        rstn = 1'b1;
        csr_read(1'b0, d);
        chk("rst_mid_status", d, 32'd0);
        watch_tx(40, low);
        chk("rst_mid_quiet", {31'd0, low}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
